// File: rtl/board_move_engine.sv
// Board-state engine for the tic-tac-toe game: owns the cell registers,
// arbitrates player/PC move requests, validates them and reports ack/nack.
module board_move_engine #(
  parameter int         NCELLS      = 9,
  parameter int         IDXW        = 4,
  parameter bit         FIRST_TURN  = 1'b0,
  parameter bit         TURN_CHECK  = 1'b1,
  parameter logic [1:0] PLAYER_CODE = 2'b01,
  parameter logic [1:0] PC_CODE     = 2'b10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  lock,
  input  logic                  play_req,
  input  logic [IDXW-1:0]       play_idx,
  input  logic                  pc_req,
  input  logic                  pc_auto,
  input  logic [IDXW-1:0]       pc_idx,
  output logic [2*NCELLS-1:0]   board,
  output logic                  busy,
  output logic                  move_ack,
  output logic                  move_nack,
  output logic [IDXW-1:0]       last_idx,
  output logic                  last_who,
  output logic                  turn,
  output logic [IDXW-1:0]       move_count,
  output logic                  full
);

  // Every index value maps to an occupancy slot; slots past the board read
  // as occupied so out-of-range targets fall out of the same test.
  localparam int NSLOTS = 1 << IDXW;

  typedef enum logic [1:0] {IDLE, CHECK, SCAN, REJECT} state_t;

  state_t          state_reg, state_next;
  logic            side_reg, side_next;
  logic [IDXW-1:0] idx_reg, idx_next;
  logic [IDXW-1:0] scan_reg, scan_next;
  logic            busy_reg, busy_next;
  logic            ack_reg, ack_next;
  logic            nack_reg, nack_next;
  logic [IDXW-1:0] last_idx_reg, last_idx_next;
  logic            last_who_reg, last_who_next;
  logic            turn_reg, turn_next;
  logic [IDXW-1:0] count_reg, count_next;
  logic            full_reg, full_next;

  logic            commit;
  logic [IDXW-1:0] commit_idx;
  logic [1:0]      commit_code;

  logic [1:0]        cells_reg [NCELLS];
  logic [NSLOTS-1:0] occupied;

  genvar gi;
  generate
    for (gi = 0; gi < NSLOTS; gi++) begin : g_occ
      if (gi < NCELLS) begin : g_real
        assign occupied[gi] = |cells_reg[gi];
      end else begin : g_pad
        assign occupied[gi] = 1'b1;
      end
    end

    for (gi = 0; gi < NCELLS; gi++) begin : g_cell
      // Cell register: cleared by reset/clear, written only by a commit.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          cells_reg[gi] <= 2'b00;
        end else if (clear) begin
          cells_reg[gi] <= 2'b00;
        end else if (commit && commit_idx == IDXW'(gi)) begin
          cells_reg[gi] <= commit_code;
        end
      end
      assign board[2*gi+1:2*gi] = cells_reg[gi];
    end
  endgenerate

  // State and output registers; clear abandons any in-flight move silently.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      side_reg     <= 1'b0;
      idx_reg      <= '0;
      scan_reg     <= '0;
      busy_reg     <= 1'b0;
      ack_reg      <= 1'b0;
      nack_reg     <= 1'b0;
      last_idx_reg <= '0;
      last_who_reg <= 1'b0;
      turn_reg     <= FIRST_TURN;
      count_reg    <= '0;
      full_reg     <= 1'b0;
    end else if (clear) begin
      state_reg    <= IDLE;
      busy_reg     <= 1'b0;
      ack_reg      <= 1'b0;
      nack_reg     <= 1'b0;
      turn_reg     <= FIRST_TURN;
      count_reg    <= '0;
      full_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      side_reg     <= side_next;
      idx_reg      <= idx_next;
      scan_reg     <= scan_next;
      busy_reg     <= busy_next;
      ack_reg      <= ack_next;
      nack_reg     <= nack_next;
      last_idx_reg <= last_idx_next;
      last_who_reg <= last_who_next;
      turn_reg     <= turn_next;
      count_reg    <= count_next;
      full_reg     <= full_next;
    end
  end

  // Arbitration, validation, scanning and commit bookkeeping.
  always_comb begin
    logic take;
    logic take_side;

    state_next    = state_reg;
    side_next     = side_reg;
    idx_next      = idx_reg;
    scan_next     = scan_reg;
    ack_next      = 1'b0;
    nack_next     = 1'b0;
    last_idx_next = last_idx_reg;
    last_who_next = last_who_reg;
    turn_next     = turn_reg;
    count_next    = count_reg;
    commit        = 1'b0;
    commit_idx    = idx_reg;
    take          = play_req | pc_req;
    take_side     = 1'b0;

    // With both sides requesting, turn order (or player priority) decides.
    if (play_req && pc_req) begin
      take_side = TURN_CHECK ? turn_reg : 1'b0;
    end else begin
      take_side = pc_req;
    end

    case (state_reg)
      IDLE: begin
        if (take) begin
          side_next = take_side;
          if (lock || (TURN_CHECK && take_side != turn_reg)) begin
            state_next = REJECT;
          end else if (take_side && pc_auto) begin
            scan_next  = '0;
            state_next = SCAN;
          end else begin
            idx_next   = take_side ? pc_idx : play_idx;
            state_next = CHECK;
          end
        end
      end
      CHECK: begin
        if (!occupied[idx_reg]) begin
          commit     = 1'b1;
          commit_idx = idx_reg;
          state_next = IDLE;
        end else begin
          state_next = REJECT;
        end
      end
      SCAN: begin
        if (!occupied[scan_reg]) begin
          commit     = 1'b1;
          commit_idx = scan_reg;
          state_next = IDLE;
        end else if (scan_reg == IDXW'(NCELLS - 1)) begin
          state_next = REJECT;
        end else begin
          scan_next = scan_reg + 1'b1;
        end
      end
      REJECT: begin
        nack_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (commit) begin
      ack_next      = 1'b1;
      last_idx_next = commit_idx;
      last_who_next = side_reg;
      count_next    = count_reg + 1'b1;
      turn_next     = ~turn_reg;
    end

    commit_code = side_reg ? PC_CODE : PLAYER_CODE;
    full_next   = (count_next == IDXW'(NCELLS));
    busy_next   = (state_next != IDLE);
  end

  assign busy       = busy_reg;
  assign move_ack   = ack_reg;
  assign move_nack  = nack_reg;
  assign last_idx   = last_idx_reg;
  assign last_who   = last_who_reg;
  assign turn       = turn_reg;
  assign move_count = count_reg;
  assign full       = full_reg;

endmodule

// File: tb/tb_board_move_engine.sv
// Directed bench for board_move_engine with the default 3x3 configuration.
module tb_board_move_engine;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        lock = 1'b0;
  logic        play_req = 1'b0;
  logic [3:0]  play_idx = '0;
  logic        pc_req = 1'b0;
  logic        pc_auto = 1'b0;
  logic [3:0]  pc_idx = '0;
  logic [17:0] board;
  logic        busy, move_ack, move_nack, last_who, turn, full;
  logic [3:0]  last_idx, move_count;

  int compared = 0;
  int mismatched = 0;

  board_move_engine dut (
    .clock(clock), .reset(reset), .clear(clear), .lock(lock),
    .play_req(play_req), .play_idx(play_idx),
    .pc_req(pc_req), .pc_auto(pc_auto), .pc_idx(pc_idx),
    .board(board), .busy(busy), .move_ack(move_ack), .move_nack(move_nack),
    .last_idx(last_idx), .last_who(last_who), .turn(turn),
    .move_count(move_count), .full(full)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle request, then wait (bounded) for the ack/nack pulse.
  task automatic do_move(input string tag, input logic side, input logic [3:0] idx,
                         input logic autob, input logic exp_ack);
    logic got_ack;
    logic seen;
    got_ack = 1'b0;
    seen = 1'b0;
    if (side) begin pc_req = 1'b1; pc_idx = idx; pc_auto = autob; end
    else begin play_req = 1'b1; play_idx = idx; end
    tick();
    play_req = 1'b0;
    pc_req = 1'b0;
    pc_auto = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick();
      if (move_ack || move_nack) begin
        seen = 1'b1;
        got_ack = move_ack;
      end
    end
    check({tag, "_done"}, 32'(seen), 32'd1);
    check({tag, "_ack"}, 32'(got_ack), 32'(exp_ack));
    $display("move %s side=%0d idx=%0d auto=%0d ack=%0d count=%0d", tag, side, idx, autob, got_ack, move_count);
  endtask

  initial begin
    tick();
    tick();
    // Reset state
    check("rst_board", 32'(board), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_turn", 32'(turn), 32'd0);
    check("rst_count", 32'(move_count), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    reset = 1'b0;
    tick();

    // Test 1: player move to cell 4, ack one edge after the CHECK edge
    play_req = 1'b1; play_idx = 4'd4;
    tick();
    play_req = 1'b0;
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_ack_early", 32'(move_ack), 32'd0);
    tick();
    check("t1_cell4", 32'(board[9:8]), 32'h1);
    check("t1_ack", 32'(move_ack), 32'd1);
    check("t1_turn", 32'(turn), 32'd1);
    check("t1_count", 32'(move_count), 32'd1);
    check("t1_last_idx", 32'(last_idx), 32'd4);
    check("t1_busy_done", 32'(busy), 32'd0);
    tick();
    check("t1_ack_pulse", 32'(move_ack), 32'd0);
    $display("t1 board=%h turn=%0d count=%0d", board, turn, move_count);

    // Set up cells 0..2 occupied with the PC to move
    do_move("pc0", 1'b1, 4'd0, 1'b0, 1'b1);
    check("pc0_who", 32'(last_who), 32'd1);
    do_move("p1", 1'b0, 4'd1, 1'b0, 1'b1);
    do_move("pc2", 1'b1, 4'd2, 1'b0, 1'b1);
    do_move("p5", 1'b0, 4'd5, 1'b0, 1'b1);
    tick();

    // Test 2: auto scan finds cell 3 after three occupied cells
    pc_req = 1'b1; pc_auto = 1'b1;
    tick();
    pc_req = 1'b0; pc_auto = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("t2_busy%0d", i), 32'(busy), 32'd1);
      check($sformatf("t2_noack%0d", i), 32'(move_ack), 32'd0);
    end
    tick();
    check("t2_ack", 32'(move_ack), 32'd1);
    check("t2_cell3", 32'(board[7:6]), 32'h2);
    check("t2_turn", 32'(turn), 32'd0);
    check("t2_last_idx", 32'(last_idx), 32'd3);
    check("t2_board", 32'(board), 32'h5A6);
    $display("t2 board=%h turn=%0d count=%0d", board, turn, move_count);

    // Test 3: occupied cell, out-of-range cell, out-of-turn, locked
    do_move("occ4", 1'b0, 4'd4, 1'b0, 1'b0);
    do_move("idx12", 1'b0, 4'd12, 1'b0, 1'b0);
    do_move("pc_oot", 1'b1, 4'd6, 1'b0, 1'b0);
    lock = 1'b1;
    do_move("locked", 1'b0, 4'd6, 1'b0, 1'b0);
    lock = 1'b0;
    check("t3_board", 32'(board), 32'h5A6);
    check("t3_turn", 32'(turn), 32'd0);
    check("t3_count", 32'(move_count), 32'd6);
    tick();

    // Test 4: simultaneous requests, player's turn wins, PC dropped quietly
    play_req = 1'b1; play_idx = 4'd6;
    pc_req = 1'b1; pc_idx = 4'd7;
    tick();
    play_req = 1'b0; pc_req = 1'b0;
    tick();
    check("t4_ack", 32'(move_ack), 32'd1);
    check("t4_board", 32'(board), 32'h15A6);
    check("t4_turn", 32'(turn), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t4_nonack%0d", i), 32'(move_nack), 32'd0);
    end
    $display("t4 board=%h turn=%0d count=%0d", board, turn, move_count);

    // Test 5: fill the board, then an auto request nacks after 9 scan cycles
    do_move("pc7", 1'b1, 4'd7, 1'b0, 1'b1);
    do_move("p8", 1'b0, 4'd8, 1'b0, 1'b1);
    check("t5_full", 32'(full), 32'd1);
    check("t5_count", 32'(move_count), 32'd9);
    check("t5_board", 32'(board), 32'h195A6);
    tick();
    pc_req = 1'b1; pc_auto = 1'b1;
    tick();
    pc_req = 1'b0; pc_auto = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check($sformatf("t5_scan_nonack%0d", i), 32'(move_nack), 32'd0);
    end
    tick();
    check("t5_nack", 32'(move_nack), 32'd1);
    check("t5_noack", 32'(move_ack), 32'd0);
    do_move("full_expl", 1'b1, 4'd0, 1'b0, 1'b0);
    $display("t5 board=%h full=%0d count=%0d", board, full, move_count);

    // Test 6a: clear during a scan drops the move
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_board", 32'(board), 32'h0);
    check("clr_turn", 32'(turn), 32'd0);
    check("clr_last_idx", 32'(last_idx), 32'd8);
    do_move("c_p0", 1'b0, 4'd0, 1'b0, 1'b1);
    tick();
    pc_req = 1'b1; pc_auto = 1'b1;
    tick();
    pc_req = 1'b0; pc_auto = 1'b0;
    tick();
    check("t6_scanning", 32'(busy), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t6_board", 32'(board), 32'h0);
    check("t6_count", 32'(move_count), 32'd0);
    check("t6_turn", 32'(turn), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_ack", 32'(move_ack), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t6_quiet%0d", i), 32'({move_ack, move_nack}), 32'd0);
    end
    check("t6_board_after", 32'(board), 32'h0);

    // Test 6b: asynchronous reset while a move sits in CHECK
    do_move("r_p0", 1'b0, 4'd0, 1'b0, 1'b1);
    tick();
    pc_req = 1'b1; pc_idx = 4'd3;
    tick();
    pc_req = 1'b0;
    check("t6b_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t6b_board", 32'(board), 32'h0);
    check("t6b_count", 32'(move_count), 32'd0);
    check("t6b_turn", 32'(turn), 32'd0);
    check("t6b_busy_rst", 32'(busy), 32'd0);
    check("t6b_last_idx", 32'(last_idx), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t6b_quiet%0d", i), 32'({move_ack, move_nack}), 32'd0);
    end
    check("t6b_board_after", 32'(board), 32'h0);
    do_move("post_rst", 1'b0, 4'd8, 1'b0, 1'b1);
    check("post_rst_board", 32'(board), 32'h10000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
